// File: rtl/scale_combiner_if.sv
// Handshake and data bundle for scale_combiner.
// Handshake rule (both sides): a beat transfers on a rising clock edge where
// valid and ready are both 1; the source holds valid and data stable until
// that edge, and ready may depend combinationally on the sink's state.
// The slave modport is the unit itself; master is the upstream/downstream side.
interface scale_combiner_if #(
  parameter int ES     = 2,
  parameter int K_BITS = 5,
  parameter int SW     = K_BITS + ES + 1
);
  // Input side
  logic                     in_valid;
  logic                     in_ready;
  logic                     op;
  logic signed [K_BITS-1:0] k_A;
  logic signed [K_BITS-1:0] k_B;
  logic        [ES-1:0]     exp_A;
  logic        [ES-1:0]     exp_B;
  logic                     sign_A;
  logic                     sign_B;
  logic                     nar_A;
  logic                     nar_B;
  logic                     zero_A;
  logic                     zero_B;
  // Output side
  logic                     out_valid;
  logic                     out_ready;
  logic signed [K_BITS-1:0] k_out;
  logic        [ES-1:0]     exp_out;
  logic signed [SW-1:0]     scale_out;
  logic                     sign_out;
  logic                     nar_out;
  logic                     zero_out;
  logic                     ovf;
  logic                     unf;

  modport slave (
    input  in_valid, op, k_A, k_B, exp_A, exp_B, sign_A, sign_B,
           nar_A, nar_B, zero_A, zero_B, out_ready,
    output in_ready, out_valid, k_out, exp_out, scale_out, sign_out,
           nar_out, zero_out, ovf, unf
  );

  modport master (
    output in_valid, op, k_A, k_B, exp_A, exp_B, sign_A, sign_B,
           nar_A, nar_B, zero_A, zero_B, out_ready,
    input  in_ready, out_valid, k_out, exp_out, scale_out, sign_out,
           nar_out, zero_out, ovf, unf
  );
endinterface

// File: rtl/scale_combiner.sv
// scale_combiner: two-stage posit scale combiner for multiply/divide.
// Stage 1 forms the operand scales (k<<ES)+exp and adds or subtracts them;
// stage 2 resolves NaR/zero, clamps to +/-((N-2)<<ES) and splits the result
// back into regime k and exponent fields.
// Optional macro SCALE_COMBINER_STATS_EN adds saturating ovf/unf/special
// counters with a synchronous clear.
module scale_combiner #(
  parameter int N      = 16,
  parameter int ES     = 2,
  parameter int K_BITS = 5,
  parameter int SW     = K_BITS + ES + 1
) (
  input  logic           clk,
  input  logic           rst,
  scale_combiner_if.slave bus
`ifdef SCALE_COMBINER_STATS_EN
  ,
  input  logic           stat_clr,
  output logic [15:0]    ovf_cnt,
  output logic [15:0]    unf_cnt,
  output logic [15:0]    special_cnt
`endif
);

  localparam logic signed [SW-1:0] MAXS = SW'((N - 2) << ES);
  localparam logic signed [SW-1:0] MINS = -MAXS;

  // ---------------- handshake control ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_advance;
  logic in_accept;
  logic out_consume;
  logic s2_load;

  assign out_consume = s2_valid_q & bus.out_ready;
  assign s1_advance  = !s2_valid_q || bus.out_ready;
  assign s2_load     = s1_valid_q & s1_advance;
  // Held low while reset is asserted so nothing is accepted into a flushing pipe.
  assign bus.in_ready = !rst && (!s1_valid_q || s1_advance);
  assign in_accept    = bus.in_valid & bus.in_ready;

  // Stage-valid next-state: load on accept, drain when the stage moves on.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (in_accept)        s1_valid_d = 1'b1;
    else if (s1_advance)  s1_valid_d = 1'b0;
    if (s2_load)          s2_valid_d = 1'b1;
    else if (out_consume) s2_valid_d = 1'b0;
  end

  // ---------------- stage 1: combine scales ----------------
  logic signed [SW-1:0] sa, sb, raw_d;
  logic signed [SW-1:0] s1_raw_q;
  logic                 s1_sign_q, s1_op_q;
  logic                 s1_nar_a_q, s1_nar_b_q, s1_zero_a_q, s1_zero_b_q;

  // SW is wide enough that neither the sum nor the difference can wrap.
  assign sa    = (SW'(bus.k_A) <<< ES) + SW'(bus.exp_A);
  assign sb    = (SW'(bus.k_B) <<< ES) + SW'(bus.exp_B);
  assign raw_d = bus.op ? (sa - sb) : (sa + sb);

  // Stage 1 registers: valid bit plus captured raw scale and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_raw_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_op_q     <= 1'b0;
      s1_nar_a_q  <= 1'b0;
      s1_nar_b_q  <= 1'b0;
      s1_zero_a_q <= 1'b0;
      s1_zero_b_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_accept) begin
        s1_raw_q    <= raw_d;
        s1_sign_q   <= bus.sign_A ^ bus.sign_B;
        s1_op_q     <= bus.op;
        s1_nar_a_q  <= bus.nar_A;
        s1_nar_b_q  <= bus.nar_B;
        s1_zero_a_q <= bus.zero_A;
        s1_zero_b_q <= bus.zero_B;
      end
    end
  end

  // ---------------- stage 2: specials, clamp, split ----------------
  logic                     nar_d, zero_d, ovf_d, unf_d, sign_d;
  logic signed [SW-1:0]     scale_d;
  logic signed [K_BITS-1:0] k_d;
  logic        [ES-1:0]     exp_d;

  // Special-case priority, then clamp and field split of the surviving scale.
  always_comb begin
    nar_d   = s1_nar_a_q | s1_nar_b_q | (s1_op_q & s1_zero_b_q);
    zero_d  = !nar_d && (s1_zero_a_q || (!s1_op_q && s1_zero_b_q));
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    sign_d  = s1_sign_q;
    scale_d = s1_raw_q;
    if (s1_raw_q > MAXS) begin
      scale_d = MAXS;
      ovf_d   = 1'b1;
    end else if (s1_raw_q < MINS) begin
      scale_d = MINS;
      unf_d   = 1'b1;
    end
    if (nar_d || zero_d) begin
      scale_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      sign_d  = 1'b0;
    end
    // Arithmetic shift floors negative scales (e.g. -3 -> k=-1, exp=1 at ES=2).
    k_d   = K_BITS'(scale_d >>> ES);
    exp_d = scale_d[ES-1:0];
  end

  logic                     s2_nar_q, s2_zero_q, s2_ovf_q, s2_unf_q, s2_sign_q;
  logic signed [SW-1:0]     s2_scale_q;
  logic signed [K_BITS-1:0] s2_k_q;
  logic        [ES-1:0]     s2_exp_q;

  // Stage 2 registers drive the outputs directly; they only change on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_scale_q <= '0;
      s2_k_q     <= '0;
      s2_exp_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_nar_q   <= nar_d;
        s2_zero_q  <= zero_d;
        s2_ovf_q   <= ovf_d;
        s2_unf_q   <= unf_d;
        s2_sign_q  <= sign_d;
        s2_scale_q <= scale_d;
        s2_k_q     <= k_d;
        s2_exp_q   <= exp_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.scale_out = s2_scale_q;
  assign bus.k_out     = s2_k_q;
  assign bus.exp_out   = s2_exp_q;
  assign bus.sign_out  = s2_sign_q;
  assign bus.nar_out   = s2_nar_q;
  assign bus.zero_out  = s2_zero_q;
  assign bus.ovf       = s2_ovf_q;
  assign bus.unf       = s2_unf_q;

`ifdef SCALE_COMBINER_STATS_EN
  logic [15:0] ovf_cnt_q, unf_cnt_q, special_cnt_q;

  // Saturating event counters, bumped once per consumed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q     <= '0;
      unf_cnt_q     <= '0;
      special_cnt_q <= '0;
    end else if (stat_clr) begin
      ovf_cnt_q     <= '0;
      unf_cnt_q     <= '0;
      special_cnt_q <= '0;
    end else if (out_consume) begin
      if (s2_ovf_q && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (s2_unf_q && unf_cnt_q != 16'hFFFF) unf_cnt_q <= unf_cnt_q + 16'd1;
      if ((s2_nar_q || s2_zero_q) && special_cnt_q != 16'hFFFF)
        special_cnt_q <= special_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt     = ovf_cnt_q;
  assign unf_cnt     = unf_cnt_q;
  assign special_cnt = special_cnt_q;
`endif

endmodule

// File: tb/tb_scale_combiner.sv
// Bench for scale_combiner: directed steps from the test plan, randomized
// traffic with random backpressure, and a scoreboard fed by an arithmetic
// reference model of the scale rules.
module tb_scale_combiner;
  localparam int N      = 16;
  localparam int ES     = 2;
  localparam int K_BITS = 5;
  localparam int SW     = K_BITS + ES + 1;
  localparam int W      = 5 + SW + K_BITS + ES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scale_combiner_if #(.ES(ES), .K_BITS(K_BITS), .SW(SW)) intf();

`ifdef SCALE_COMBINER_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] ovf_cnt, unf_cnt, special_cnt;
`endif

  scale_combiner #(.N(N), .ES(ES), .K_BITS(K_BITS), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
`ifdef SCALE_COMBINER_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .ovf_cnt     (ovf_cnt),
    .unf_cnt     (unf_cnt),
    .special_cnt (special_cnt)
`endif
  );

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Packed result: {sign, nar, zero, ovf, unf, scale, k, exp}
  function automatic logic [W-1:0] model(bit op, int ka, int ea, bit sga, bit na, bit za,
                                         int kb, int eb, bit sgb, bit nb, bit zb);
    int step = 1 << ES;
    int s_a  = ka * step + ea;
    int s_b  = kb * step + eb;
    int maxs = (N - 2) * step;
    int s    = op ? (s_a - s_b) : (s_a + s_b);
    bit nar  = na | nb | (op & zb);
    bit zero = !nar && (za || (!op && zb));
    bit o = 1'b0, u = 1'b0;
    int k, e;
    logic [SW-1:0]     sv;
    logic [K_BITS-1:0] kv;
    logic [ES-1:0]     ev;
    if (nar || zero) return {1'b0, nar, zero, 2'b00, {(SW + K_BITS + ES){1'b0}}};
    if (s > maxs) begin s = maxs; o = 1'b1; end
    else if (s < -maxs) begin s = -maxs; u = 1'b1; end
    k  = (s >= 0) ? s / step : -((-s + step - 1) / step);
    e  = s - k * step;
    sv = SW'(s);
    kv = K_BITS'(k);
    ev = ES'(e);
    return {sga ^ sgb, 1'b0, 1'b0, o, u, sv, kv, ev};
  endfunction

  function automatic logic [W-1:0] obs_pack();
    return {intf.sign_out, intf.nar_out, intf.zero_out, intf.ovf, intf.unf,
            intf.scale_out, intf.k_out, intf.exp_out};
  endfunction

  // ---------------- scoreboard ----------------
  // Every consumed result is compared against the model value queued at accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (intf.out_valid && intf.out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          assert (1'b0) else begin
            fail_cnt++;
            $error("FAIL sb_unexpected: got %h with no expected entry", obs_pack());
          end
        end else begin
          logic [W-1:0] want;
          want = exp_q.pop_front();
          assert (obs_pack() === want) else begin
            fail_cnt++;
            $error("FAIL sb_result: got %h expected %h", obs_pack(), want);
          end
        end
      end
      if (intf.in_valid && intf.in_ready)
        exp_q.push_back(model(intf.op, int'(intf.k_A), int'(intf.exp_A), intf.sign_A,
                              intf.nar_A, intf.zero_A, int'(intf.k_B), int'(intf.exp_B),
                              intf.sign_B, intf.nar_B, intf.zero_B));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(string tag, int obs, int exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(bit op, int ka, int ea, bit sga, bit na, bit za,
                            int kb, int eb, bit sgb, bit nb, bit zb);
    intf.op     = op;
    intf.k_A    = K_BITS'(ka);
    intf.exp_A  = ES'(ea);
    intf.sign_A = sga;
    intf.nar_A  = na;
    intf.zero_A = za;
    intf.k_B    = K_BITS'(kb);
    intf.exp_B  = ES'(eb);
    intf.sign_B = sgb;
    intf.nar_B  = nb;
    intf.zero_B = zb;
  endtask

  // Present one transaction and wait (bounded) for the accepting edge.
  task automatic send(bit op, int ka, int ea, bit sga, bit na, bit za,
                      int kb, int eb, bit sgb, bit nb, bit zb);
    int guard = 0;
    set_inputs(op, ka, ea, sga, na, za, kb, eb, sgb, nb, zb);
    intf.in_valid = 1'b1;
    @(negedge clk);
    while (!intf.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("send_accept_timeout", int'(guard < 200), 1);
    @(posedge clk);
    #1;
    intf.in_valid = 1'b0;
  endtask

  // One transaction into an empty pipe with out_ready high; checks latency and fields.
  task automatic single(string tag, bit op, int ka, int ea, bit sga, bit na, bit za,
                        int kb, int eb, bit sgb, bit nb, bit zb,
                        int e_scale, int e_k, int e_exp, bit e_sign, bit e_nar,
                        bit e_zero, bit e_ovf, bit e_unf);
    send(op, ka, ea, sga, na, za, kb, eb, sgb, nb, zb);
    check({tag, "_valid_early"}, int'(intf.out_valid), 0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, int'(intf.out_valid), 1);
    check({tag, "_scale"}, int'(intf.scale_out), e_scale);
    check({tag, "_k"},     int'(intf.k_out), e_k);
    check({tag, "_exp"},   int'(intf.exp_out), e_exp);
    check({tag, "_sign"},  int'(intf.sign_out), int'(e_sign));
    check({tag, "_nar"},   int'(intf.nar_out), int'(e_nar));
    check({tag, "_zero"},  int'(intf.zero_out), int'(e_zero));
    check({tag, "_ovf"},   int'(intf.ovf), int'(e_ovf));
    check({tag, "_unf"},   int'(intf.unf), int'(e_unf));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    intf.out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 1000) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    set_inputs(1'($urandom_range(0, 1)),
               int'($urandom_range(0, 29)) - 15, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0,
               int'($urandom_range(0, 29)) - 15, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int acc;
    int sent;
    int cyc;
    bit accepted;
    int bk_op[3] = '{0, 1, 1};
    int bk_ka[3] = '{2, 2, 1};
    int bk_ea[3] = '{3, 3, 2};
    int bk_kb[3] = '{1, 1, 2};
    int bk_eb[3] = '{2, 2, 3};

    intf.in_valid  = 1'b0;
    intf.out_ready = 1'b1;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(intf.out_valid), 0);
    check("rst_scale", int'(intf.scale_out), 0);
    check("rst_flags", int'({intf.nar_out, intf.zero_out, intf.ovf, intf.unf, intf.sign_out}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(intf.in_ready), 1);
    @(posedge clk);
    #1;

    // Main function and clamps
    single("mul",    0,   2, 3, 0, 0, 0,   1, 2, 1, 0, 0,  17,   4, 1, 1, 0, 0, 0, 0);
    single("div",    1,   2, 3, 0, 0, 0,   1, 2, 1, 0, 0,   5,   1, 1, 1, 0, 0, 0, 0);
    single("div_neg",1,   1, 2, 0, 0, 0,   2, 3, 0, 0, 0,  -5,  -2, 3, 0, 0, 0, 0, 0);
    single("ovf",    0,  14, 3, 0, 0, 0,  14, 3, 0, 0, 0,  56,  14, 0, 0, 0, 0, 1, 0);
    single("unf",    0, -15, 0, 0, 0, 0, -15, 0, 0, 0, 0, -56, -14, 0, 0, 0, 0, 0, 1);
    single("floor",  1,   0, 1, 0, 0, 0,   1, 0, 0, 0, 0,  -3,  -1, 1, 0, 0, 0, 0, 0);

    // Specials
    single("div_zb", 1,   2, 3, 1, 0, 0,   1, 2, 0, 0, 1,   0,   0, 0, 0, 1, 0, 0, 0);
    single("mul_za", 0,   2, 3, 1, 0, 1,   1, 2, 0, 0, 0,   0,   0, 0, 0, 0, 1, 0, 0);
    single("nar_zb", 0,   2, 3, 0, 1, 0,   1, 2, 1, 0, 1,   0,   0, 0, 0, 1, 0, 0, 0);
    single("div_za", 1,  14, 3, 1, 0, 1,  -15, 0, 0, 0, 0,  0,   0, 0, 0, 0, 1, 0, 0);

    // Backpressure: only two of three back-to-back inputs fit
    intf.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      set_inputs(bk_op[i] != 0, bk_ka[i], bk_ea[i], 1'b0, 1'b0, 1'b0,
                 bk_kb[i], bk_eb[i], 1'b1, 1'b0, 1'b0);
      intf.in_valid = 1'b1;
      @(negedge clk);
      if (intf.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted", acc, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(intf.in_ready), 0);
      check("bp_hold", int'(obs_pack()),
            int'(model(0, 2, 3, 0, 0, 0, 1, 2, 1, 0, 0)));
    end
    @(posedge clk);
    #1;
    intf.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_release_valid", int'(intf.out_valid), 1);
      @(posedge clk);
      #1;
      if (j == 0) intf.in_valid = 1'b0;
    end
    drain();

    // Randomized traffic with random backpressure
    sent = 0;
    cyc  = 0;
    while (sent < 300 && cyc < 5000) begin
      intf.out_ready = $urandom_range(0, 3) != 0;
      if (!intf.in_valid && $urandom_range(0, 3) != 0) begin
        rand_inputs();
        intf.in_valid = 1'b1;
      end
      @(negedge clk);
      accepted = intf.in_valid && intf.in_ready;
      @(posedge clk);
      #1;
      if (accepted) begin
        intf.in_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    intf.in_valid = 1'b0;
    check("rand_sent", sent, 300);
    drain();

    // Reset with both stages full
    intf.out_ready = 1'b0;
    send(0, 3, 1, 0, 0, 0, 2, 2, 0, 0, 0);
    send(1, 3, 1, 0, 0, 0, 2, 2, 0, 0, 0);
    check("full_out_valid", int'(intf.out_valid), 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(intf.out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    intf.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", int'(intf.out_valid), 0);
    end
    check("post_rst_in_ready", int'(intf.in_ready), 1);
    @(posedge clk);
    #1;

`ifdef SCALE_COMBINER_STATS_EN
    check("stats_rst_ovf", int'(ovf_cnt), 0);
    check("stats_rst_special", int'(special_cnt), 0);
    for (int i = 0; i < 3; i++) send(0, 14, 3, 0, 0, 0, 14, 3, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    drain();
    check("stats_ovf", int'(ovf_cnt), 3);
    check("stats_unf", int'(unf_cnt), 0);
    check("stats_special", int'(special_cnt), 1);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("stats_clr_ovf", int'(ovf_cnt), 0);
    check("stats_clr_special", int'(special_cnt), 0);
`endif

    drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/scale_combiner.md
Name: scale_combiner

Overview:
- Pipelined, parametrised posit scale unit for the multiply/divide datapath.
- Per transaction, combines operand scales (k<<ES)+exp by adding (multiply) or subtracting (divide), and XORs the signs.
- Resolves NaR and zero special cases, clamps the result to the posit dynamic range, and re-splits it into regime k and exponent fields for the encoder.
- Successor to the single-shot exponent adder: adds a valid/ready pipeline, a divide mode, range clamping and width generalisation.

Parameters:
- N, 16, posit word width; sets the legal scale range.
- ES, 2, exponent field width.
- K_BITS, 5, signed regime width; must represent -(N-1)..(N-2).
- SW, K_BITS+ES+1, signed internal scale width; holds any sum or difference without wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept input this cycle.
- op  in  1  0 = multiply (add scales), 1 = divide (A minus B).
- k_A, k_B  in  K_BITS  signed regime values.
- exp_A, exp_B  in  ES  unsigned exponent fields.
- sign_A, sign_B  in  1  operand signs.
- nar_A, nar_B  in  1  operand is NaR.
- zero_A, zero_B  in  1  operand is zero.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- k_out  out  K_BITS  signed regime of the clamped scale.
- exp_out  out  ES  exponent of the clamped scale.
- scale_out  out  SW  signed clamped scale.
- sign_out  out  1  result sign.
- nar_out  out  1  result is NaR.
- zero_out  out  1  result is zero.
- ovf  out  1  scale was clamped high.
- unf  out  1  scale was clamped low.

Behaviour:
- Reset: all outputs and both stage-valid bits are 0; in_ready=1 once reset deasserts.
- Reset mid-operation flushes both stages immediately; in-flight data is discarded.
- Handshakes: input is accepted when in_valid and in_ready are both 1. Output is consumed when out_valid and out_ready are both 1.
- Pipeline: two register stages.
  - S1 captures sA=(k_A<<<ES)+exp_A and sB likewise, all sign-extended to SW.
  - S1 computes raw = op ? sA-sB : sA+sB. It also registers sign = sign_A^sign_B, op, and the special-case flags.
  - S2 clamps raw, splits it into k and exp, and drives the outputs.
- Latency: 2 cycles from input accept to out_valid, with no stall.
- Throughput: 1 transaction per cycle.
- Stall rules:
  - S2 holds while out_valid=1 and out_ready=0.
  - S1 advances when S2 is empty or being consumed.
  - in_ready = !s1_valid || s1_advance (combinational). A full pipe with out_ready=0 gives in_ready=0.
  - Outputs stay stable while stalled.
- Clamp limits: MAXS=(N-2)<<ES, MINS=-MAXS.
  - raw>MAXS: scale_out=MAXS, ovf=1.
  - raw<MINS: scale_out=MINS, unf=1.
  - Otherwise scale_out=raw and ovf=unf=0.
- Field split: k_out = scale_out>>>ES (arithmetic shift); exp_out = scale_out[ES-1:0]. Negative scales floor, e.g. -3 with ES=2 gives k=-1, exp=1.
- Special-case priority, highest first:
  - nar_A | nar_B → nar_out=1.
  - Divide with zero_B → nar_out=1.
  - Multiply with zero_A | zero_B, or divide with zero_A → zero_out=1.
  - Whenever nar_out or zero_out is 1: scale_out=0, k_out=0, exp_out=0, ovf=unf=0, sign_out=0.
- Simultaneous input accept and output consume in the same cycle is legal and loses no bubble.
- Wrap is impossible by construction of SW; no modular wrap is permitted.

Optional Feature:
- Macro SCALE_COMBINER_STATS_EN.
- When defined, adds the following ports:
  - stat_clr  in  1
  - ovf_cnt  out  16
  - unf_cnt  out  16
  - special_cnt  out  16
- Each counter increments once per consumed output with ovf, unf, or nar_out|zero_out respectively.
- Counters saturate at 16'hFFFF.
- stat_clr is a synchronous clear and takes priority over an increment.
- rst clears all counters.
- When not defined, none of these ports or registers exist.

Test Plan:
- Multiply: k_A=2, exp_A=3, k_B=1, exp_B=2, signs 0/1 → scale_out=17, k_out=4, exp_out=1, sign_out=1, out_valid 2 cycles after accept.
- Divide: same operands with op=1 → scale_out=5, k_out=1, exp_out=1; a further divide of 6−11 → scale_out=-5, k_out=-2, exp_out=3.
- Clamp: multiply k=14, exp=3 on both operands → raw=118, scale_out=56, k_out=14, exp_out=0, ovf=1. Multiply k=-15, exp=0 on both → scale_out=-56, k_out=-14, unf=1.
- Specials:
  - Divide with zero_B=1 → nar_out=1.
  - Multiply with zero_A=1 → zero_out=1, scale_out=0.
  - nar_A together with zero_B → nar_out=1, zero_out=0.
- Backpressure: hold out_ready=0 and present 3 back-to-back inputs → only 2 are accepted, in_ready=0, outputs hold. Release out_ready → results emerge in order, one per cycle.
- Reset mid-stream: assert rst with both stages full → out_valid=0 immediately and no stale result after release. With SCALE_COMBINER_STATS_EN, 3 clamped results give ovf_cnt=3, and stat_clr returns it to 0.
